// File: rtl/da_bit_serializer.sv
// da_bit_serializer: FIFO-buffered parallel-to-serial feeder for the DA FIR filter.
// Ports: clock, i_reset (sync, active-high), i_data/i_valid/o_ready (push handshake),
//        o_data/o_enable/o_sof (LSB-first serial stream), o_level (FIFO occupancy).
module da_bit_serializer #(
    parameter int NB_DATA_IN = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int NB_PTR     = 2
) (
    input  logic                  clock,
    input  logic                  i_reset,
    input  logic [NB_DATA_IN-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_data,
    output logic                  o_enable,
    output logic                  o_sof,
    output logic [NB_PTR:0]       o_level
);

    localparam int NB_CNT = (NB_DATA_IN > 1) ? $clog2(NB_DATA_IN) : 1;
    localparam logic [NB_CNT-1:0] LAST_BIT = NB_CNT'(NB_DATA_IN - 1);
    localparam logic [NB_PTR:0]   FULL     = (NB_PTR + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state;
    state_t                state_next;
    logic [NB_DATA_IN-1:0] mem [FIFO_DEPTH];
    logic [NB_PTR-1:0]     wr_ptr;
    logic [NB_PTR-1:0]     rd_ptr;
    logic [NB_PTR:0]       count;
    logic [NB_PTR:0]       count_next;
    logic [NB_DATA_IN-1:0] shreg;
    logic [NB_DATA_IN-1:0] shreg_next;
    logic [NB_CNT-1:0]     bit_cnt;
    logic [NB_CNT-1:0]     bit_cnt_next;
    logic                  sof;
    logic                  sof_next;
    logic                  push;
    logic                  pop;

    // Full is judged on the registered count, so a same-edge pop never frees a slot.
    assign o_ready  = (count != FULL);
    assign o_level  = count;
    assign o_enable = (state == SHIFT);
    assign o_data   = shreg[0];
    assign o_sof    = sof;

    always_comb begin
        push         = i_valid && o_ready;
        pop          = 1'b0;
        state_next   = state;
        shreg_next   = shreg;
        bit_cnt_next = bit_cnt;
        sof_next     = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    pop          = 1'b1;
                    state_next   = SHIFT;
                    shreg_next   = mem[rd_ptr];
                    bit_cnt_next = '0;
                    sof_next     = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
                    if (count != '0) begin
                        // back-to-back word: no idle cycle between frames
                        pop          = 1'b1;
                        shreg_next   = mem[rd_ptr];
                        bit_cnt_next = '0;
                        sof_next     = 1'b1;
                    end else begin
                        state_next   = IDLE;
                        shreg_next   = '0;
                        bit_cnt_next = '0;
                    end
                end else begin
                    shreg_next   = shreg >> 1;
                    bit_cnt_next = bit_cnt + 1'b1;
                end
            end
        endcase
        count_next = count + {{NB_PTR{1'b0}}, push} - {{NB_PTR{1'b0}}, pop};
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
            sof     <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            shreg   <= shreg_next;
            bit_cnt <= bit_cnt_next;
            sof     <= sof_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: occupancy alone says which entries are live.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= i_data;
    end

endmodule

// File: tb/tb_da_bit_serializer.sv
// tb_da_bit_serializer: random + directed bench with a queue-based reference model.
// Checks every output each cycle, frame reassembly, and a few hand-derived literals.
module tb_da_bit_serializer;

    localparam int NB    = 8;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       i_reset;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic       o_data;
    logic       o_enable;
    logic       o_sof;
    logic [2:0] o_level;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    da_bit_serializer #(.NB_DATA_IN(NB), .FIFO_DEPTH(DEPTH), .NB_PTR(2)) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_enable(o_enable),
        .o_sof   (o_sof),
        .o_level (o_level)
    );

    always #5 clock = ~clock;

    // Reference model: a word queue plus "which bit of which word is on the wire".
    logic [7:0] mq[$];
    logic [7:0] exp_words[$];
    bit         m_act = 1'b0;
    logic [7:0] m_word = '0;
    int         m_idx = 0;
    bit         m_push;
    bit         m_pop;

    always @(posedge clock) begin
        if (i_reset) begin
            mq.delete();
            exp_words.delete();
            m_act = 1'b0;
            m_idx = 0;
        end else begin
            m_push = i_valid && (mq.size() < DEPTH);
            m_pop  = (!m_act || m_idx == NB - 1) && (mq.size() > 0);
            if (m_pop) begin
                m_word = mq.pop_front();
                m_act  = 1'b1;
                m_idx  = 0;
            end else if (m_act) begin
                if (m_idx == NB - 1) m_act = 1'b0;
                else m_idx++;
            end
            if (m_push) begin
                mq.push_back(i_data);
                exp_words.push_back(i_data);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare plus reassembly of serial frames into words.
    logic [7:0] fw;
    int         fbits = 0;

    always @(negedge clock) begin
        if (chk_on) begin
            check("enable", int'(o_enable), int'(m_act));
            check("data", int'(o_data), m_act ? int'(m_word[m_idx]) : 0);
            check("sof", int'(o_sof), int'(m_act && m_idx == 0));
            check("level", int'(o_level), mq.size());
            check("ready", int'(o_ready), int'(mq.size() != DEPTH));
            if (o_enable) begin
                if (o_sof) fbits = 0;
                fw[fbits[2:0]] = o_data;
                fbits++;
                if (fbits == NB) begin
                    fbits = 0;
                    if (exp_words.size() == 0)
                        check("frame_extra", int'(fw), -1);
                    else
                        check("frame_word", int'(fw), int'(exp_words.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic push_one(input logic [7:0] d);
        i_valid = 1'b1;
        i_data  = d;
        tick();
        i_valid = 1'b0;
    endtask

    logic [7:0] bits;
    logic [7:0] sofs;
    logic [7:0] ens;
    logic [7:0] w [6];
    int         k;
    int         acc5;
    bit         r;

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        tick();
        tick();
        i_reset = 1'b0;
        check("rst_enable", int'(o_enable), 0);
        check("rst_level", int'(o_level), 0);
        check("rst_ready", int'(o_ready), 1);
        check("rst_data", int'(o_data), 0);
        chk_on = 1'b1;

        // Single A5 burst: pin the serial order literally.
        push_one(8'hA5);
        check("t1_level_after_push", int'(o_level), 1);
        check("t1_idle_before", int'(o_enable), 0);
        for (int i = 0; i < NB; i++) begin
            tick();
            bits[i] = o_data;
            sofs[i] = o_sof;
            ens[i]  = o_enable;
        end
        check("t1_bits", int'(bits), 8'hA5);
        check("t1_sof", int'(sofs), 8'h01);
        check("t1_en", int'(ens), 8'hFF);
        tick();
        check("t1_en_after", int'(o_enable), 0);
        repeat (3) tick();

        // Two back-to-back words: 16 contiguous enabled cycles.
        i_valid = 1'b1;
        i_data  = 8'h01;
        tick();
        i_data  = 8'h80;
        tick();
        i_valid = 1'b0;
        for (int i = 0; i < 2 * NB; i++) begin
            if (i == 8) check("t2_sof2", int'(o_sof), 1);
            check("t2_en", int'(o_enable), 1);
            tick();
        end
        check("t2_en_after", int'(o_enable), 0);
        repeat (3) tick();

        // Hold valid with six words: fifth push fills, sixth waits for a pop.
        for (int i = 0; i < 6; i++) w[i] = 8'(8'h30 + i);
        k = 0;
        acc5 = -1;
        i_valid = 1'b1;
        for (int e = 0; e < 14; e++) begin
            i_data = w[k];
            r = o_ready;
            tick();
            if (r) begin
                if (k == 5) acc5 = e;
                k++;
            end
            if (e == 4) begin
                check("t3_level_full", int'(o_level), 4);
                check("t3_ready_full", int'(o_ready), 0);
            end
            if (k == 6) break;
        end
        i_valid = 1'b0;
        check("t3_w5_edge", acc5, 10);
        repeat (40) tick();

        // Reset during the 4th bit with two words queued.
        i_valid = 1'b1;
        i_data  = 8'hC3;
        tick();
        i_data  = 8'h5A;
        tick();
        i_data  = 8'h96;
        tick();
        i_valid = 1'b0;
        tick();
        check("t4_level_q", int'(o_level), 2);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("t4_enable", int'(o_enable), 0);
        check("t4_level", int'(o_level), 0);
        check("t4_ready", int'(o_ready), 1);
        for (int i = 0; i < 10; i++) begin
            check("t4_quiet", int'(o_enable), 0);
            tick();
        end

        // Two bursts separated by a long idle gap.
        push_one(8'h7F);
        repeat (20) tick();
        push_one(8'h80);
        tick();
        check("t5_second_start", int'(o_enable), 1);
        check("t5_second_sof", int'(o_sof), 1);
        repeat (12) tick();

        // Random traffic; the source holds its word while not ready.
        for (int c = 0; c < 3000; c++) begin
            if (!(i_valid && !o_ready)) begin
                i_valid = ($urandom_range(0, 3) != 0);
                i_data  = 8'($urandom);
            end
            i_reset = ($urandom_range(0, 399) == 0);
            tick();
            if (c % 500 == 499) begin
                i_valid = 1'b0;
                i_reset = 1'b0;
                repeat ($urandom_range(0, 20)) tick();
            end
        end
        i_valid = 1'b0;
        i_reset = 1'b0;
        repeat (60) tick();
        check("drain_words_left", exp_words.size(), 0);
        check("drain_level", int'(o_level), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
